// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops plus shift-add multiply and restoring divide.
// Optional signed MULH/DIV/REM on opcodes 13-15 when ITER_ALU_SIGNED_MD_EN is defined.
module iter_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             busy
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_MULHU = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_REMU  = 4'd12;
`ifdef ITER_ALU_SIGNED_MD_EN
  localparam logic [3:0] OP_MULH  = 4'd13;
  localparam logic [3:0] OP_DIV   = 4'd14;
  localparam logic [3:0] OP_REM   = 4'd15;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_d;
`ifdef ITER_ALU_SIGNED_MD_EN
  logic             r_neg;
`endif

  logic [SHW-1:0]   w_shamt;
  logic             w_slt;
  logic [WIDTH-1:0] w_single;
  logic             w_in_iter;
  logic             w_in_div;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
`ifdef ITER_ALU_SIGNED_MD_EN
  logic             w_in_sgn;
  logic             w_neg;
`endif
  logic             w_is_div;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_md_res;

  assign w_shamt = b[SHW-1:0];
  assign w_slt   = $signed(a) < $signed(b);

  always_comb begin
    w_single = '0;
    case (alu_ctl)
      OP_AND: w_single = a & b;
      OP_OR:  w_single = a | b;
      OP_ADD: w_single = a + b;
      OP_XOR: w_single = a ^ b;
      OP_SLL: w_single = a << w_shamt;
      OP_SRL: w_single = a >> w_shamt;
      OP_SUB: w_single = a - b;
      OP_SLT: w_single = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SRA: w_single = $signed(a) >>> w_shamt;
      default: w_single = '0;
    endcase
  end

  always_comb begin
    w_in_iter = 1'b0;
    w_in_div  = 1'b0;
    case (alu_ctl)
      OP_MUL, OP_MULHU: w_in_iter = 1'b1;
      OP_DIVU, OP_REMU: begin
        w_in_iter = 1'b1;
        w_in_div  = 1'b1;
      end
`ifdef ITER_ALU_SIGNED_MD_EN
      OP_MULH: w_in_iter = 1'b1;
      OP_DIV, OP_REM: begin
        w_in_iter = 1'b1;
        w_in_div  = 1'b1;
      end
`endif
      default: begin
        w_in_iter = 1'b0;
        w_in_div  = 1'b0;
      end
    endcase
  end

`ifdef ITER_ALU_SIGNED_MD_EN
  // Signed ops run the unsigned core on magnitudes; r_neg records the final negation.
  assign w_in_sgn = (alu_ctl == OP_MULH) || (alu_ctl == OP_DIV) || (alu_ctl == OP_REM);
  assign w_mag_a  = (w_in_sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_mag_b  = (w_in_sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;

  always_comb begin
    w_neg = 1'b0;
    case (alu_ctl)
      OP_MULH: w_neg = a[WIDTH-1] ^ b[WIDTH-1];
      OP_DIV:  w_neg = (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
      OP_REM:  w_neg = a[WIDTH-1];
      default: w_neg = 1'b0;
    endcase
  end
`else
  assign w_mag_a = a;
  assign w_mag_b = b;
`endif

  always_comb begin
    w_is_div = 1'b0;
    case (r_op)
      OP_DIVU, OP_REMU: w_is_div = 1'b1;
`ifdef ITER_ALU_SIGNED_MD_EN
      OP_DIV, OP_REM:   w_is_div = 1'b1;
`endif
      default:          w_is_div = 1'b0;
    endcase
  end

  // Multiply: {r_hi,r_lo} is the product/multiplier pair shifted right each step.
  // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : {(WIDTH+1){1'b0}});
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_d};
  assign w_rem   = w_shift[WIDTH-1:0] - r_d;

  always_comb begin
    if (w_is_div) begin
      w_hi_nxt = w_ge ? w_rem : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nxt = w_msum[WIDTH:1];
      w_lo_nxt = {w_msum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_md_res = '0;
    case (r_op)
      OP_MUL, OP_DIVU:  w_md_res = w_lo_nxt;
      OP_MULHU, OP_REMU: w_md_res = w_hi_nxt;
`ifdef ITER_ALU_SIGNED_MD_EN
      // High half of the negated 2*WIDTH product: carry in only when the low half is zero.
      OP_MULH: w_md_res = r_neg ? (~w_hi_nxt + {{(WIDTH-1){1'b0}}, (w_lo_nxt == '0)}) : w_hi_nxt;
      OP_DIV:  w_md_res = r_neg ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
      OP_REM:  w_md_res = r_neg ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
`endif
      default: w_md_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_cnt       <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_d         <= '0;
`ifdef ITER_ALU_SIGNED_MD_EN
      r_neg       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op       <= alu_ctl;
            r_in_ready <= 1'b0;
            if (w_in_iter) begin
              r_hi    <= '0;
              r_lo    <= w_in_div ? w_mag_a : w_mag_b;
              r_d     <= w_in_div ? w_mag_b : w_mag_a;
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= S_CALC;
`ifdef ITER_ALU_SIGNED_MD_EN
              r_neg   <= w_neg;
`endif
            end else begin
              r_result    <= w_single;
              r_zero      <= (w_single == '0);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_result    <= w_md_res;
            r_zero      <= (w_md_res == '0);
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero       = r_zero;
  assign busy       = r_busy;

endmodule
